// File: rtl/posit_dec_if.sv
// ============================================================================
// Module      : posit_dec_if
// Description : Handshake bundle between a posit word source and the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface posit_dec_if #(
  parameter int N  = 32,
  parameter int ES = 2
);
  localparam int SW = $clog2(N) + ES + 1;
  localparam int FW = N - ES - 3;

  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0]         posit_i;
  logic                 out_valid;
  logic                 out_ready;
  logic                 sign_o;
  logic                 zero_o;
  logic                 nar_o;
  logic signed [SW-1:0] scale_o;
  logic [FW-1:0]        frac_o;

  modport master (
    output in_valid, posit_i, out_ready,
    input  in_ready, out_valid, sign_o, zero_o, nar_o, scale_o, frac_o
  );

  modport slave (
    input  in_valid, posit_i, out_ready,
    output in_ready, out_valid, sign_o, zero_o, nar_o, scale_o, frac_o
  );
endinterface

`default_nettype wire

// File: rtl/posit_decoder.sv
// ============================================================================
// Module      : posit_decoder
// Description : Multi-cycle posit<N,ES> unpacker, regime scanned one bit/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module posit_decoder #(
  parameter int N  = 32,
  parameter int ES = 2
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  posit_dec_if.slave  bus
);
  localparam int SW = $clog2(N) + ES + 1;
  localparam int FW = N - ES - 3;
  localparam int RW = $clog2(N);
  localparam logic [RW-1:0] c_RUN_MAX = RW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_NEG     = 3'd1,
    S_SCAN    = 3'd2,
    S_EXTRACT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [N-1:0]    r_word;
  logic            r_sign;
  logic            r_r0;
  logic [N-3:0]    r_sr;
  logic [RW-1:0]   r_run;
  logic            r_out_sign;
  logic            r_out_zero;
  logic            r_out_nar;
  logic [SW-1:0]   r_out_scale;
  logic [FW-1:0]   r_out_frac;

  logic            w_low_zero;
  logic            w_continue;
  logic [N-1:0]    w_work;
  logic [SW-1:0]   w_run_ext;
  logic [SW-1:0]   w_k;
  logic [SW-1:0]   w_e;
  logic [SW-1:0]   w_scale;
  logic [FW-1:0]   w_frac;
  logic [1:0]      w_unused;

  assign w_low_zero = (bus.posit_i[N-2:0] == '0);
  assign w_continue = (r_sr[N-3] == r_r0) && (r_run != c_RUN_MAX);
  assign w_work     = r_sign ? (~r_word + N'(1)) : r_word;
  assign w_run_ext  = {{(SW-RW){1'b0}}, r_run};
  assign w_k        = r_r0 ? (w_run_ext - SW'(1)) : (~w_run_ext + SW'(1));
  assign w_scale    = (w_k << ES) + w_e;
  // Bit 0 of the shift register is always padding once the terminator is consumed.
  assign w_frac     = r_sr[N-ES-3:1];
  assign w_unused   = {r_sr[0], w_work[N-1]};

  if (ES > 0) begin : g_exp
    assign w_e = {{(SW-ES){1'b0}}, r_sr[N-3 -: ES]};
  end else begin : g_no_exp
    assign w_e = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.in_valid) w_next = w_low_zero ? S_DONE : S_NEG;
      S_NEG:     w_next = S_SCAN;
      S_SCAN:    if (!w_continue) w_next = S_EXTRACT;
      S_EXTRACT: w_next = S_DONE;
      S_DONE:    if (bus.out_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word      <= '0;
      r_sign      <= 1'b0;
      r_r0        <= 1'b0;
      r_sr        <= '0;
      r_run       <= '0;
      r_out_sign  <= 1'b0;
      r_out_zero  <= 1'b0;
      r_out_nar   <= 1'b0;
      r_out_scale <= '0;
      r_out_frac  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_word <= bus.posit_i;
            r_sign <= bus.posit_i[N-1];
            if (w_low_zero) begin
              r_out_sign  <= bus.posit_i[N-1];
              r_out_zero  <= ~bus.posit_i[N-1];
              r_out_nar   <= bus.posit_i[N-1];
              r_out_scale <= '0;
              r_out_frac  <= '0;
            end
          end
        end
        S_NEG: begin
          r_r0  <= w_work[N-2];
          r_run <= RW'(1);
          r_sr  <= w_work[N-3:0];
        end
        S_SCAN: begin
          if (w_continue) begin
            r_run <= r_run + RW'(1);
            r_sr  <= r_sr << 1;
          end else if (r_run != c_RUN_MAX) begin
            r_sr  <= r_sr << 1;
          end
        end
        S_EXTRACT: begin
          r_out_sign  <= r_sign;
          r_out_zero  <= 1'b0;
          r_out_nar   <= 1'b0;
          r_out_scale <= w_scale;
          r_out_frac  <= w_frac;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.sign_o    = r_out_sign;
  assign bus.zero_o    = r_out_zero;
  assign bus.nar_o     = r_out_nar;
  assign bus.scale_o   = r_out_scale;
  assign bus.frac_o    = r_out_frac;
endmodule

`default_nettype wire

// File: tb/tb_posit_decoder.sv
// ============================================================================
// Module      : tb_posit_decoder
// Description : Directed self-checking bench for posit_decoder (N=32, ES=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_posit_decoder;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  posit_dec_if #(.N(32), .ES(2)) bus ();

  posit_decoder #(.N(32), .ES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Presents one word, counts edges from the accept edge (inclusive) until out_valid.
  task automatic send_wait(input logic [31:0] w, output int lat);
    bus.posit_i  = w;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq("idle_in_ready", longint'(bus.in_ready), 1);
  endtask

  task automatic decode(input string tag, input logic [31:0] w, input int exp_lat,
                        input int exp_sign, input int exp_zero, input int exp_nar,
                        input int exp_scale, input longint exp_frac);
    int lat;
    send_wait(w, lat);
    check_eq({tag, "_lat"},   longint'(lat), longint'(exp_lat));
    check_eq({tag, "_sign"},  longint'(bus.sign_o), longint'(exp_sign));
    check_eq({tag, "_zero"},  longint'(bus.zero_o), longint'(exp_zero));
    check_eq({tag, "_nar"},   longint'(bus.nar_o), longint'(exp_nar));
    check_eq({tag, "_scale"}, longint'($signed(bus.scale_o)), longint'(exp_scale));
    check_eq({tag, "_frac"},  longint'(bus.frac_o), exp_frac);
    check_eq({tag, "_rdy0"},  longint'(bus.in_ready), 0);
    release_out();
  endtask

  initial begin
    int lat;
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.posit_i   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready",  longint'(bus.in_ready), 1);
    check_eq("rst_out_valid", longint'(bus.out_valid), 0);
    check_eq("rst_scale",     longint'($signed(bus.scale_o)), 0);
    check_eq("rst_frac",      longint'(bus.frac_o), 0);
    check_eq("rst_flags",     longint'({bus.sign_o, bus.zero_o, bus.nar_o}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency is m+3 edges (accept, NEG, m SCAN, EXTRACT); specials take 1 edge.
    decode("one",      32'h4000_0000,  4, 0, 0, 0,    0, 64'h0);
    decode("neg_one",  32'hC000_0000,  4, 1, 0, 0,    0, 64'h0);
    decode("two",      32'h4800_0000,  4, 0, 0, 0,    1, 64'h0);
    decode("one_p5",   32'h4400_0000,  4, 0, 0, 0,    0, 64'h400_0000);
    decode("neg_two",  32'hB800_0000,  4, 1, 0, 0,    1, 64'h0);
    decode("sub_one",  32'h3FFF_FFFF,  4, 0, 0, 0,   -1, 64'h7FF_FFFF);
    decode("maxpos",   32'h7FFF_FFFF, 34, 0, 0, 0,  120, 64'h0);
    decode("minpos",   32'h0000_0001, 33, 0, 0, 0, -120, 64'h0);
    decode("zero",     32'h0000_0000,  1, 0, 1, 0,    0, 64'h0);
    decode("nar",      32'h8000_0000,  1, 1, 0, 1,    0, 64'h0);

    // Backpressure: DONE held with a competing word offered on the input.
    send_wait(32'h4800_0000, lat);
    check_eq("bp_lat", longint'(lat), 4);
    bus.posit_i  = 32'h7FFF_FFFF;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("bp_valid", longint'(bus.out_valid), 1);
      check_eq("bp_ready", longint'(bus.in_ready), 0);
      check_eq("bp_scale", longint'($signed(bus.scale_o)), 1);
      check_eq("bp_frac",  longint'(bus.frac_o), 0);
    end
    bus.in_valid = 1'b0;
    release_out();
    check_eq("bp_valid_drop", longint'(bus.out_valid), 0);
    decode("after_bp", 32'h4400_0000, 4, 0, 0, 0, 0, 64'h400_0000);

    // Asynchronous abort in the middle of a long regime scan.
    bus.posit_i  = 32'h7FFF_FFFF;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("scan_busy", longint'(bus.in_ready), 0);
    rst_n = 1'b0;
    #1;
    check_eq("abort_valid", longint'(bus.out_valid), 0);
    check_eq("abort_ready", longint'(bus.in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_eq("abort_no_out", longint'(bus.out_valid), 0);
    decode("after_rst", 32'h4000_0000, 4, 0, 0, 0, 0, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
